// File: rtl/spad_pingpong_if.sv
// Producer/consumer bundle for the ping-pong scratchpad: streaming write port,
// random-access registered read port, and bank-ownership status.
interface spad_pingpong_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int ADDR  = $clog2(DEPTH)
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic             wr_ready;

    logic             rd_bank_ready;
    logic [ADDR:0]    rd_len;
    logic             rd_en;
    logic [ADDR-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_done;

    logic             wr_bank;
    logic             rd_bank;

    // Producer and PE side: drives requests, observes status and read data.
    modport master (
        output wr_valid, wr_data, wr_last,
        input  wr_ready,
        input  rd_bank_ready, rd_len,
        output rd_en, rd_addr,
        input  rd_data, rd_valid,
        output rd_done,
        input  wr_bank, rd_bank
    );

    // Scratchpad side.
    modport slave (
        input  wr_valid, wr_data, wr_last,
        output wr_ready,
        output rd_bank_ready, rd_len,
        input  rd_en, rd_addr,
        output rd_data, rd_valid,
        input  rd_done,
        output wr_bank, rd_bank
    );
endinterface

// File: rtl/spad_pingpong.sv
// Double-buffered scratchpad: the producer fills one bank while the PE reads the
// other; per-bank EMPTY/FILL/FULL state hands each bank between the two sides.
module spad_pingpong #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    spad_pingpong_if.slave        bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_st_t;

    bank_st_t         st     [2];
    bank_st_t         st_nxt [2];
    logic [ADDR:0]    len     [2];
    logic [ADDR:0]    len_nxt [2];
    logic             wb, wb_nxt;
    logic             rb, rb_nxt;
    logic [ADDR-1:0]  wp, wp_nxt;

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    logic             wr_ready_int;
    logic             rd_ready_int;
    logic             wr_fire;
    logic             wr_complete;
    logic             rd_fire;
    logic             rel_fire;
    logic             rd_in_range;

    // Handshake qualifiers. Accept and release can never target the same bank
    // in one cycle: accept needs a non-FULL write bank, release a FULL reader bank.
    assign wr_ready_int = !rst && (st[wb] != FULL);
    assign rd_ready_int = (st[rb] == FULL);
    assign wr_fire      = bus.wr_valid && wr_ready_int;
    assign wr_complete  = wr_fire && (bus.wr_last || (wp == ADDR'(DEPTH - 1)));
    assign rd_fire      = bus.rd_en && rd_ready_int;
    assign rel_fire     = bus.rd_done && rd_ready_int;
    assign rd_in_range  = ({1'b0, bus.rd_addr} < len[rb]);

    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        st_nxt  = st;
        len_nxt = len;
        wb_nxt  = wb;
        rb_nxt  = rb;
        wp_nxt  = wp;

        if (wr_fire) begin
            st_nxt[wb] = FILL;
            wp_nxt     = wp + 1'b1;
            if (wr_complete) begin
                st_nxt[wb]  = FULL;
                len_nxt[wb] = {1'b0, wp} + 1'b1;
                wp_nxt      = '0;
                wb_nxt      = ~wb;
            end
        end

        if (rel_fire) begin
            st_nxt[rb]  = EMPTY;
            len_nxt[rb] = '0;
            rb_nxt      = ~rb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0]  <= EMPTY;
            st[1]  <= EMPTY;
            len[0] <= '0;
            len[1] <= '0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            wp     <= '0;
        end else begin
            st[0]  <= st_nxt[0];
            st[1]  <= st_nxt[1];
            len[0] <= len_nxt[0];
            len[1] <= len_nxt[1];
            wb     <= wb_nxt;
            rb     <= rb_nxt;
            wp     <= wp_nxt;
        end
    end

    // NOTE: the storage array has no reset; stale words are hidden by len
    // gating on the read side, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wb][wp] <= bus.wr_data;
        end
    end

    // Read uses the pre-edge reader bank, so a same-cycle release still reads
    // from the bank being handed back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (rd_fire) begin
            rd_data_q  <= rd_in_range ? mem[rb][bus.rd_addr] : '0;
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.wr_ready      = wr_ready_int;
    assign bus.rd_bank_ready = rd_ready_int;
    assign bus.rd_len        = rd_ready_int ? len[rb] : '0;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.wr_bank       = wb;
    assign bus.rd_bank       = rb;

endmodule

// File: tb/tb_spad_pingpong.sv
// Directed bench for spad_pingpong: fill, short tile, overlap/stall, same-cycle
// read+release, ignored requests, and asynchronous reset mid-fill and mid-read.
module tb_spad_pingpong;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int ADDR  = 6;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    spad_pingpong_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) bus ();

    spad_pingpong #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_done  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"},  32'(bus.wr_ready),      32'd0);
        check({tag, "_rd_ready"},  32'(bus.rd_bank_ready), 32'd0);
        check({tag, "_rd_len"},    32'(bus.rd_len),        32'd0);
        check({tag, "_rd_valid"},  32'(bus.rd_valid),      32'd0);
        check({tag, "_rd_data"},   32'(bus.rd_data),       32'd0);
        check({tag, "_wr_bank"},   32'(bus.wr_bank),       32'd0);
        check({tag, "_rd_bank"},   32'(bus.rd_bank),       32'd0);
    endtask

    task automatic read_word(input string tag, input int addr, input int exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR'(addr);
        tick();
        bus.rd_en   = 1'b0;
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_data"},  32'(bus.rd_data),  32'(exp));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();

        // Reset state
        #3;
        check_reset_outputs("rst0");
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Full 64-word tile, completion on the DEPTH-th word without wr_last
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = WIDTH'(i);
            tick();
            if (i == DEPTH - 2)
                check("fill63_not_ready", 32'(bus.rd_bank_ready), 32'd0);
        end
        bus.wr_valid = 1'b0;
        check("fill_rd_ready", 32'(bus.rd_bank_ready), 32'd1);
        check("fill_rd_len",   32'(bus.rd_len),        32'd64);
        check("fill_wr_bank",  32'(bus.wr_bank),       32'd1);
        check("fill_rd_bank",  32'(bus.rd_bank),       32'd0);
        check("fill_wr_ready", 32'(bus.wr_ready),      32'd1);

        read_word("rd0",  0,  8'h00);
        read_word("rd63", 63, 8'h3F);
        read_word("rd17", 17, 8'h11);
        tick();
        check("rd_idle_valid", 32'(bus.rd_valid), 32'd0);
        check("rd_idle_hold",  32'(bus.rd_data),  32'h11);

        // Overlap: short 5-word tile into bank 1 while reading bank 0 each cycle
        for (int i = 0; i < 5; i++) begin
            check("ovl_wr_ready", 32'(bus.wr_ready), 32'd1);
            bus.wr_valid = 1'b1;
            bus.wr_data  = WIDTH'(8'hA0 + i);
            bus.wr_last  = (i == 4);
            bus.rd_en    = 1'b1;
            bus.rd_addr  = ADDR'(i + 40);
            tick();
            check("ovl_rd_valid", 32'(bus.rd_valid), 32'd1);
            check("ovl_rd_data",  32'(bus.rd_data),  32'(40 + i));
        end
        bus.rd_en   = 1'b0;
        bus.wr_last = 1'b0;

        // Third tile stalls: both banks FULL
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hC0;
        check("stall_wr_bank",  32'(bus.wr_bank),  32'd0);
        check("stall_wr_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        tick();
        check("stall2_wr_ready", 32'(bus.wr_ready), 32'd0);

        // Same-cycle read + release of bank 0; wr_ready still low this cycle (bubble)
        bus.rd_en   = 1'b1;
        bus.rd_done = 1'b1;
        bus.rd_addr = ADDR'(2);
        tick();
        bus.rd_en   = 1'b0;
        bus.rd_done = 1'b0;
        check("rel_rd_valid",  32'(bus.rd_valid),      32'd1);
        check("rel_rd_data",   32'(bus.rd_data),       32'h02);
        check("rel_rd_bank",   32'(bus.rd_bank),       32'd1);
        check("rel_rd_ready",  32'(bus.rd_bank_ready), 32'd1);
        check("rel_rd_len",    32'(bus.rd_len),        32'd5);
        check("rel_wr_ready",  32'(bus.wr_ready),      32'd1);

        // Resume writing into bank 0: C0, C1, C2 (last)
        tick();
        bus.wr_data = 8'hC1;
        tick();
        bus.wr_data = 8'hC2;
        bus.wr_last = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        check("t3_wr_bank",  32'(bus.wr_bank),  32'd1);
        check("t3_wr_ready", 32'(bus.wr_ready), 32'd0);

        // Short-tile boundary reads in bank 1
        read_word("short_rd4", 4, 8'hA4);
        read_word("short_rd5", 5, 8'h00);

        // Release bank 1 alone
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("rel1_rd_bank",  32'(bus.rd_bank),  32'd0);
        check("rel1_rd_len",   32'(bus.rd_len),   32'd3);
        check("rel1_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rel1_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Stale word from the 64-word tile must stay hidden
        read_word("stale_rd3", 3, 8'h00);
        read_word("t3_rd2",    2, 8'hC2);

        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        check("rel0_rd_bank",  32'(bus.rd_bank),       32'd1);
        check("rel0_rd_ready", 32'(bus.rd_bank_ready), 32'd0);
        check("rel0_rd_len",   32'(bus.rd_len),        32'd0);

        // Ignored requests with no FULL bank
        bus.rd_en   = 1'b1;
        bus.rd_done = 1'b1;
        bus.rd_addr = ADDR'(0);
        tick();
        bus.rd_en   = 1'b0;
        bus.rd_done = 1'b0;
        check("ign_rd_valid", 32'(bus.rd_valid),      32'd0);
        check("ign_rd_data",  32'(bus.rd_data),       32'hC2);
        check("ign_rd_bank",  32'(bus.rd_bank),       32'd1);
        check("ign_rd_ready", 32'(bus.rd_bank_ready), 32'd0);

        // Asynchronous reset mid-fill (3 words into bank 1)
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = WIDTH'(8'hD0 + i);
            tick();
        end
        bus.wr_valid = 1'b0;
        check("midfill_wr_bank", 32'(bus.wr_bank), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_fill");
        tick();
        rst = 1'b0;

        // Mid-read reset: 2-word tile, read, then reset while rd_valid is high
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hE0;
        tick();
        bus.wr_data  = 8'hE1;
        bus.wr_last  = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        read_word("pre_rst_rd1", 1, 8'hE1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_read");
        tick();
        rst = 1'b0;

        // Post-reset 2-word tile
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hF0;
        tick();
        bus.wr_data  = 8'hF1;
        bus.wr_last  = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        check("post_rd_ready", 32'(bus.rd_bank_ready), 32'd1);
        check("post_rd_len",   32'(bus.rd_len),        32'd2);
        read_word("post_rd0", 0, 8'hF0);
        read_word("post_rd1", 1, 8'hF1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
